// File: rtl/wb_arb_pkg.sv
// Shared widths, the x0 register index and grant encoding for the register-file write-port arbiter.
package wb_arb_pkg;
  localparam int         WB_DW   = 32;
  localparam int         WB_AW   = 5;
  localparam logic [4:0] ZeroReg = 5'd0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_FIFO = 2'd2
  } gnt_e;
endpackage

// File: rtl/wb_arb_fifo.sv
// Long-latency result FIFO with a per-entry live bit and kill-by-address.
// Dead entries stay in order and are popped by the arbiter without using the port.
module wb_arb_fifo import wb_arb_pkg::*; #(
  parameter int DW    = WB_DW,
  parameter int AW    = WB_AW,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [AW-1:0] i_push_addr,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_push_live,
  input  logic          i_pop,
  input  logic          i_kill,
  input  logic [AW-1:0] i_kill_addr,
  output logic [AW-1:0] o_head_addr,
  output logic [DW-1:0] o_head_data,
  output logic          o_head_live,
  output logic          o_full,
  output logic          o_empty
);
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [PW-1:0] r_rd, r_wr;
  logic [PW:0]   r_cnt;
  logic          w_push, w_pop;

  assign o_full      = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty     = (r_cnt == '0);
  assign w_push      = i_push & ~o_full;
  assign w_pop       = i_pop & ~o_empty;
  assign o_head_addr = r_addr[r_rd];
  assign o_head_data = r_data[r_rd];
  assign o_head_live = r_live[r_rd] & ~o_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      r_live <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      // Kill first so a same-cycle push into a freed slot keeps its own live bit.
      for (int i = 0; i < DEPTH; i++)
        if (i_kill && r_addr[i] == i_kill_addr) r_live[i] <= 1'b0;
      if (w_push) begin
        r_addr[r_wr] <= i_push_addr;
        r_data[r_wr] <= i_push_data;
        r_live[r_wr] <= i_push_live;
        r_wr         <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/wb_arb.sv
// Register-file write-port arbiter: pipeline write-back has priority, long-latency results queue
// and drain when the port is free; a starved head forces a one-cycle pipeline stall.
// Optional WB_ARB_STAT_EN adds conflict/force statistics counters.
module wb_arb import wb_arb_pkg::*; #(
  parameter int DW       = WB_DW,
  parameter int AW       = WB_AW,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_we_i,
  input  logic [AW-1:0] pipe_waddr_i,
  input  logic [DW-1:0] pipe_wdata_i,
  output logic          pipe_stall_o,
  input  logic          lu_valid_i,
  input  logic [AW-1:0] lu_waddr_i,
  input  logic [DW-1:0] lu_wdata_i,
  output logic          lu_ready_o,
  output logic          reg_we_o,
  output logic [AW-1:0] reg_waddr_o,
  output logic [DW-1:0] reg_wdata_o
`ifdef WB_ARB_STAT_EN
  ,
  output logic [31:0]   conflict_cnt_o,
  output logic [31:0]   force_cnt_o
`endif
);
  localparam logic [AW-1:0] ZR = AW'(ZeroReg);

  logic [AW-1:0] w_head_addr;
  logic [DW-1:0] w_head_data;
  logic          w_head_live, w_full, w_empty;
  logic          w_sat, w_pop, w_kill, w_push, w_push_live;
  gnt_e          w_gnt;
  logic [3:0]    r_starve;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;

  // x0 results are queued dead so they never contend for the port or stall the pipe.
  assign w_push_live = (lu_waddr_i != ZR);
  assign w_sat       = (r_starve == 4'(MAX_WAIT));

  always_comb begin
    w_gnt = GNT_NONE;
    if (w_sat && w_head_live && pipe_we_i) w_gnt = GNT_FIFO;
    else if (pipe_we_i)                    w_gnt = GNT_PIPE;
    else if (w_head_live)                  w_gnt = GNT_FIFO;
  end

  assign pipe_stall_o = pipe_we_i && (w_gnt == GNT_FIFO);
  assign lu_ready_o   = ~w_full;
  assign w_pop        = ~w_empty && ((w_gnt == GNT_FIFO) || !w_head_live);
  assign w_kill       = (w_gnt == GNT_PIPE);
  // A same-address lu result arriving with a pipeline write is older, so it is dropped.
  assign w_push       = lu_valid_i && ~w_full && !(w_kill && lu_waddr_i == pipe_waddr_i);

  wb_arb_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_addr (lu_waddr_i),
    .i_push_data (lu_wdata_i),
    .i_push_live (w_push_live),
    .i_pop       (w_pop),
    .i_kill      (w_kill),
    .i_kill_addr (pipe_waddr_i),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_head_live (w_head_live),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      if (w_empty || w_pop)                                  r_starve <= '0;
      else if (w_head_live && w_gnt != GNT_FIFO && !w_sat)   r_starve <= r_starve + 1'b1;
      unique case (w_gnt)
        GNT_PIPE: begin
          r_we    <= (pipe_waddr_i != ZR);
          r_waddr <= pipe_waddr_i;
          r_wdata <= pipe_wdata_i;
        end
        GNT_FIFO: begin
          r_we    <= (w_head_addr != ZR);
          r_waddr <= w_head_addr;
          r_wdata <= w_head_data;
        end
        default: r_we <= 1'b0;
      endcase
    end
  end

  assign reg_we_o    = r_we;
  assign reg_waddr_o = r_waddr;
  assign reg_wdata_o = r_wdata;

`ifdef WB_ARB_STAT_EN
  logic [31:0] r_conflict, r_force;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_conflict <= '0;
      r_force    <= '0;
    end else begin
      if (pipe_we_i && w_head_live) r_conflict <= r_conflict + 1'b1;
      if (pipe_stall_o)             r_force    <= r_force + 1'b1;
    end
  end
  assign conflict_cnt_o = r_conflict;
  assign force_cnt_o    = r_force;
`endif
endmodule

// File: tb/tb_wb_arb.sv
// Bench for wb_arb: directed vector table, reset-mid-drain sequence, then random traffic
// checked against a queue-based reference model.
module tb_wb_arb;
  localparam int DW = 32, AW = 5, DEPTH = 2, MAXW = 4;

  logic          clk = 1'b0, rst = 1'b0;
  logic          pipe_we_i = 1'b0, lu_valid_i = 1'b0;
  logic [AW-1:0] pipe_waddr_i = '0, lu_waddr_i = '0;
  logic [DW-1:0] pipe_wdata_i = '0, lu_wdata_i = '0;
  logic          pipe_stall_o, lu_ready_o, reg_we_o;
  logic [AW-1:0] reg_waddr_o;
  logic [DW-1:0] reg_wdata_o;
`ifdef WB_ARB_STAT_EN
  logic [31:0]   conflict_cnt_o, force_cnt_o;
`endif

  always #5 clk = ~clk;

  wb_arb #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .pipe_we_i(pipe_we_i), .pipe_waddr_i(pipe_waddr_i), .pipe_wdata_i(pipe_wdata_i),
    .pipe_stall_o(pipe_stall_o),
    .lu_valid_i(lu_valid_i), .lu_waddr_i(lu_waddr_i), .lu_wdata_i(lu_wdata_i),
    .lu_ready_o(lu_ready_o),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o)
`ifdef WB_ARB_STAT_EN
    , .conflict_cnt_o(conflict_cnt_o), .force_cnt_o(force_cnt_o)
`endif
  );

  typedef struct {
    bit pwe; logic [4:0] pa; logic [31:0] pd;
    bit lv;  logic [4:0] la; logic [31:0] ld;
    bit st;  bit rd; bit we; logic [4:0] wa; logic [31:0] wd;
  } vec_t;
  typedef struct { logic [4:0] a; logic [31:0] d; bit live; } ent_t;

  ent_t        q[$];
  int          starve, m_conf, m_force;
  bit          m_we, m_stall, m_acc;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          n_tests = 0, n_fail = 0;
  vec_t        tv[$];

  function automatic vec_t V(bit pwe, int pa, int pd, bit lv, int la, int ld,
                             bit st, bit rd, bit we, int wa, int wd);
    vec_t r;
    r.pwe = pwe; r.pa = 5'(pa); r.pd = 32'(pd);
    r.lv  = lv;  r.la = 5'(la); r.ld = 32'(ld);
    r.st  = st;  r.rd = rd; r.we = we; r.wa = 5'(wa); r.wd = 32'(wd);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete(); starve = 0; m_we = 0; m_wa = '0; m_wd = '0; m_conf = 0; m_force = 0;
    m_stall = 0; m_acc = 0;
  endtask

  task automatic drive(input vec_t v);
    pipe_we_i = v.pwe; pipe_waddr_i = v.pa; pipe_wdata_i = v.pd;
    lu_valid_i = v.lv; lu_waddr_i = v.la;   lu_wdata_i = v.ld;
  endtask

  // One clock: check combinational outputs before the edge, registered outputs after it.
  task automatic cycle(input bit tab, input vec_t v);
    bit hl, frc, rdy, pop;
    int g;
    #1;
    hl  = q.size() > 0 && q[0].live && q[0].a != 0;
    frc = (starve == MAXW) && hl && pipe_we_i;
    rdy = q.size() < DEPTH;
    g   = frc ? 2 : pipe_we_i ? 1 : hl ? 2 : 0;
    pop = q.size() > 0 && (g == 2 || !hl);
    chk("stall", 32'(pipe_stall_o), tab ? 32'(v.st) : 32'(frc));
    chk("ready", 32'(lu_ready_o),   tab ? 32'(v.rd) : 32'(rdy));
    @(posedge clk); #1;
    if (pipe_we_i && hl) m_conf++;
    if (frc) m_force++;
    if (g == 1) begin
      m_we = (pipe_waddr_i != 0); m_wa = pipe_waddr_i; m_wd = pipe_wdata_i;
      foreach (q[i]) if (q[i].a == pipe_waddr_i) q[i].live = 0;
    end else if (g == 2) begin
      m_we = 1; m_wa = q[0].a; m_wd = q[0].d;
    end else m_we = 0;
    if (q.size() == 0 || pop) starve = 0;
    else if (hl && g != 2 && starve < MAXW) starve++;
    if (pop) void'(q.pop_front());
    if (lu_valid_i && rdy && !(g == 1 && lu_waddr_i == pipe_waddr_i))
      q.push_back('{lu_waddr_i, lu_wdata_i, 1'b1});
    m_stall = frc;
    m_acc   = lu_valid_i && rdy;
    if (tab) begin
      chk("we", 32'(reg_we_o), 32'(v.we));
      if (v.we) begin
        chk("waddr", 32'(reg_waddr_o), 32'(v.wa));
        chk("wdata", reg_wdata_o, v.wd);
      end
    end else begin
      chk("m_we",    32'(reg_we_o),    32'(m_we));
      chk("m_waddr", 32'(reg_waddr_o), 32'(m_wa));
      chk("m_wdata", reg_wdata_o,      m_wd);
    end
  endtask

  initial begin
    vec_t idle;
    idle = V(0,0,0, 0,0,0, 0,1, 0,0,0);
    //        pwe pa  pd      lv la ld      st rd we wa wd
    tv.push_back(V(1, 5, 'hA5,  0, 0, 0,     0, 1, 1, 5, 'hA5));
    tv.push_back(V(0, 0, 0,     1, 7, 'h11,  0, 1, 0, 0, 0));
    tv.push_back(V(0, 0, 0,     1, 8, 'h22,  0, 1, 1, 7, 'h11));
    tv.push_back(V(0, 0, 0,     0, 0, 0,     0, 1, 1, 8, 'h22));
    tv.push_back(idle);
    tv.push_back(V(1, 1, 'h100, 1, 9, 'h99,  0, 1, 1, 1, 'h100));
    tv.push_back(V(1, 2, 'h101, 0, 0, 0,     0, 1, 1, 2, 'h101));
    tv.push_back(V(1, 3, 'h102, 0, 0, 0,     0, 1, 1, 3, 'h102));
    tv.push_back(V(1, 4, 'h103, 0, 0, 0,     0, 1, 1, 4, 'h103));
    tv.push_back(V(1, 5, 'h104, 0, 0, 0,     0, 1, 1, 5, 'h104));
    tv.push_back(V(1, 6, 'h105, 0, 0, 0,     1, 1, 1, 9, 'h99));
    tv.push_back(V(1, 6, 'h105, 0, 0, 0,     0, 1, 1, 6, 'h105));
    tv.push_back(V(1, 1, 'h201, 1, 3, 'h33,  0, 1, 1, 1, 'h201));
    tv.push_back(V(1, 2, 'h202, 1, 4, 'h44,  0, 1, 1, 2, 'h202));
    tv.push_back(V(1, 1, 'h203, 1, 6, 'h66,  0, 0, 1, 1, 'h203));
    tv.push_back(V(0, 0, 0,     1, 6, 'h66,  0, 0, 1, 3, 'h33));
    tv.push_back(V(0, 0, 0,     1, 6, 'h66,  0, 1, 1, 4, 'h44));
    tv.push_back(V(0, 0, 0,     0, 0, 0,     0, 1, 1, 6, 'h66));
    tv.push_back(idle);
    tv.push_back(V(0, 0, 0,     1, 10, 'h1,  0, 1, 0, 0, 0));
    tv.push_back(V(1, 10, 'h2,  0, 0, 0,     0, 1, 1, 10, 'h2));
    tv.push_back(idle);
    tv.push_back(V(1, 10, 'h3,  1, 10, 'h4,  0, 1, 1, 10, 'h3));
    tv.push_back(idle);
    tv.push_back(V(0, 0, 0,     1, 0, 'h55,  0, 1, 0, 0, 0));
    tv.push_back(idle);
    tv.push_back(V(1, 0, 'h77,  0, 0, 0,     0, 1, 0, 0, 0));
    tv.push_back(idle);

    model_reset();
    #12;
    chk("rst_we",    32'(reg_we_o),    0);
    chk("rst_waddr", 32'(reg_waddr_o), 0);
    chk("rst_wdata", reg_wdata_o,      0);
    chk("rst_stall", 32'(pipe_stall_o), 0);
    #10 rst = 1'b1;
    #1 chk("rst_ready", 32'(lu_ready_o), 1);
    @(posedge clk); #1;

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i]);
      cycle(1, tv[i]);
    end

    // Reset while two results are queued and one is draining.
    drive(V(1, 1, 'h301, 1, 11, 'hB, 0,0,0,0,0)); cycle(0, idle);
    drive(V(1, 2, 'h302, 1, 12, 'hC, 0,0,0,0,0)); cycle(0, idle);
    drive(idle); cycle(0, idle);
    chk("drain_x11", 32'(reg_waddr_o), 11);
    #3 rst = 1'b0;
    #1;
    chk("arst_we",    32'(reg_we_o),     0);
    chk("arst_waddr", 32'(reg_waddr_o),  0);
    chk("arst_wdata", reg_wdata_o,       0);
    chk("arst_stall", 32'(pipe_stall_o), 0);
    model_reset();
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      cycle(0, idle);
      chk("post_rst_we", 32'(reg_we_o), 0);
    end

    for (int i = 0; i < 800; i++) begin
      int pct;
      pct = (i < 300) ? 35 : 80;
      if (!m_stall) begin
        pipe_we_i    = ($urandom_range(0, 99) < pct);
        pipe_waddr_i = 5'($urandom_range(0, 7));
        pipe_wdata_i = $urandom;
      end
      if (!lu_valid_i || m_acc) begin
        lu_valid_i = ($urandom_range(0, 99) < 45);
        lu_waddr_i = 5'($urandom_range(0, 7));
        lu_wdata_i = $urandom;
      end
      cycle(0, idle);
    end

`ifdef WB_ARB_STAT_EN
    chk("conflict_cnt", conflict_cnt_o, 32'(m_conf));
    chk("force_cnt",    force_cnt_o,    32'(m_force));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
